// File: rtl/edge_arb_pkg.sv
// Shared types and the round-robin search used by the edge event arbiter.
// The search is written once at the widest supported line count and narrowed by callers.
package edge_arb_pkg;

  localparam int MAX_CH  = 16;
  localparam int MAX_IDW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1
  } state_t;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } pick_t;

  // First set bit of vec at or after ptr, wrapping within the first n lines.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0]  vec,
                                    input logic [MAX_IDW-1:0] ptr,
                                    input int                 n);
    pick_t res;
    int    j;
    res = '0;
    for (int k = 0; k < MAX_CH; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if ((k < n) && !res.found && (j < MAX_CH) && vec[j[MAX_IDW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[MAX_IDW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/edge_rr_pick.sv
// Combinational round-robin finder: lowest set bit of i_vec scanning upward
// from i_ptr with wrap-around.
module edge_rr_pick
  import edge_arb_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int IDW  = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_vec,
  input  logic [IDW-1:0]  i_ptr,
  output logic            o_found,
  output logic [IDW-1:0]  o_idx
);

  pick_t w_pick;
  logic  w_unused_pick;

  always_comb begin
    w_pick = rr_pick(MAX_CH'(i_vec), MAX_IDW'(i_ptr), N_CH);
  end

  assign o_found       = w_pick.found;
  assign o_idx         = w_pick.idx[IDW-1:0];
  assign w_unused_pick = ^w_pick.idx;

endmodule

// File: rtl/edge_event_arbiter.sv
// Captures rising edges on N_CH lines into sticky pending flags and serves them
// one at a time over valid/ready in round-robin order (Moore FSM).
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int IDW  = $clog2(N_CH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_in_lines,
  input  logic            i_en,
  output logic            o_evt_valid,
  input  logic            i_evt_ready,
  output logic [IDW-1:0]  o_evt_id,
  output logic [N_CH-1:0] o_pending,
  output logic [N_CH-1:0] o_overflow,
  input  logic            i_ovf_clr,
  output logic [1:0]      o_dbg_state
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N_CH-1:0] r_line_q;
  logic [N_CH-1:0] r_pending;
  logic [N_CH-1:0] r_overflow;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_evt_id;

  logic            w_handshake;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_consume;
  logic [N_CH-1:0] w_pending_nxt;
  logic [N_CH-1:0] w_overflow_nxt;
  logic [IDW-1:0]  w_rr_ptr_nxt;
  logic [IDW-1:0]  w_evt_id_nxt;
  logic            w_idle_found;
  logic [IDW-1:0]  w_idle_idx;
  logic            w_b2b_found;
  logic [IDW-1:0]  w_b2b_idx;

  // A rise coinciding with its own consume keeps the line pending without overflow.
  always_comb begin
    w_handshake = (r_state == ST_OFFER) && i_evt_ready;
    w_rise      = i_in_lines & ~r_line_q;
    w_consume   = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_consume[i] = w_handshake && (r_evt_id == IDW'(i));
    end
    w_pending_nxt  = r_pending & ~w_consume;
    w_overflow_nxt = i_ovf_clr ? '0 : r_overflow;
    if (i_en) begin
      w_pending_nxt  = w_pending_nxt | w_rise;
      w_overflow_nxt = w_overflow_nxt | (w_rise & r_pending & ~w_consume);
    end
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_handshake) begin
      w_rr_ptr_nxt = (r_evt_id == IDW'(N_CH - 1)) ? '0 : r_evt_id + IDW'(1);
    end
  end

  edge_rr_pick #(.N_CH(N_CH)) u_idle_pick (
    .i_vec   (r_pending),
    .i_ptr   (r_rr_ptr),
    .o_found (w_idle_found),
    .o_idx   (w_idle_idx)
  );

  // Picks the follow-on offer from post-handshake flags so offers run without a bubble.
  edge_rr_pick #(.N_CH(N_CH)) u_b2b_pick (
    .i_vec   (w_pending_nxt),
    .i_ptr   (w_rr_ptr_nxt),
    .o_found (w_b2b_found),
    .o_idx   (w_b2b_idx)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_evt_id_nxt = r_evt_id;
    case (r_state)
      ST_IDLE: begin
        if (w_idle_found) begin
          w_state_nxt  = ST_OFFER;
          w_evt_id_nxt = w_idle_idx;
        end
      end
      ST_OFFER: begin
        if (w_handshake) begin
          if (w_b2b_found) w_evt_id_nxt = w_b2b_idx;
          else             w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_line_q   <= '1;
      r_pending  <= '0;
      r_overflow <= '0;
      r_rr_ptr   <= '0;
      r_evt_id   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_line_q   <= i_in_lines;
      r_pending  <= w_pending_nxt;
      r_overflow <= w_overflow_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_evt_id   <= w_evt_id_nxt;
    end
  end

  always_comb begin
    o_evt_valid = (r_state == ST_OFFER);
    o_evt_id    = r_evt_id;
    o_pending   = r_pending;
    o_overflow  = r_overflow;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: each step drives inputs, waits one
// clock edge, then compares outputs against hand-computed values.
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] inLines;
  logic       en;
  logic       evtValid;
  logic       evtReady;
  logic [1:0] evtId;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       ovfClr;
  logic [1:0] dbgState;

  int compareCount  = 0;
  int mismatchCount = 0;

  edge_event_arbiter #(.N_CH(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_lines  (inLines),
    .i_en        (en),
    .o_evt_valid (evtValid),
    .i_evt_ready (evtReady),
    .o_evt_id    (evtId),
    .o_pending   (pending),
    .o_overflow  (overflow),
    .i_ovf_clr   (ovfClr),
    .o_dbg_state (dbgState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic [3:0] lines, input logic enIn,
                               input logic readyIn, input logic clrIn, input logic rstIn);
    inLines  = lines;
    en       = enIn;
    evtReady = readyIn;
    ovfClr   = clrIn;
    rst      = rstIn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOffer(input string tag, input logic validExp, input logic [1:0] idExp);
    checkOutput({tag, "_valid"}, 32'(evtValid), 32'(validExp));
    if (validExp) checkOutput({tag, "_id"}, 32'(evtId), 32'(idExp));
  endtask

  initial begin
    inLines = 4'b1111; en = 1'b1; evtReady = 1'b0; ovfClr = 1'b0; rst = 1'b1;

    // Reset with all lines held high
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_valid",    32'(evtValid), 32'd0);
    checkOutput("rst_id",       32'(evtId),    32'd0);
    checkOutput("rst_pending",  32'(pending),  32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_dbg",      32'(dbgState), 32'd0);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_pending", 32'(pending), 32'd0);
    checkOffer("post_rst", 1'b0, 2'd0);

    // Test 1: line 2 drops and rises
    applyStimulus(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_pending", 32'(pending), 32'h4);
    checkOffer("t1_pre", 1'b0, 2'd0);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOffer("t1_offer", 1'b1, 2'd2);
    checkOutput("t1_dbg", 32'(dbgState), 32'd1);
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOffer("t1_done", 1'b0, 2'd0);
    checkOutput("t1_pending_done", 32'(pending), 32'h0);

    // Test 2: fresh reset so the round-robin pointer starts at 0
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_pending", 32'(pending), 32'hB);
    applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOffer("t2_first", 1'b1, 2'd0);
    applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOffer("t2_second", 1'b1, 2'd1);
    applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOffer("t2_third", 1'b1, 2'd3);
    checkOutput("t2_pending_third", 32'(pending), 32'h8);
    applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOffer("t2_idle", 1'b0, 2'd0);
    checkOutput("t2_dbg_idle", 32'(dbgState), 32'd0);
    checkOutput("t2_pending_idle", 32'(pending), 32'h0);

    // Test 3: serve id 1 alone, then lines 0 and 2 together
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOffer("t3_id1", 1'b1, 2'd1);
    applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOffer("t3_id1_done", 1'b0, 2'd0);
    applyStimulus(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_pending", 32'(pending), 32'h5);
    applyStimulus(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOffer("t3_first", 1'b1, 2'd2);
    applyStimulus(4'b0111, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOffer("t3_second", 1'b1, 2'd0);
    applyStimulus(4'b0111, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOffer("t3_idle", 1'b0, 2'd0);

    // Test 4: stalled offer of id 3 while line 3 rises again
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_pending", 32'(pending), 32'h8);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOffer("t4_offer", 1'b1, 2'd3);
    applyStimulus(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOffer("t4_stall1", 1'b1, 2'd3);
    checkOutput("t4_ovf_none", 32'(overflow), 32'h0);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOffer("t4_stall2", 1'b1, 2'd3);
    checkOutput("t4_ovf_set", 32'(overflow), 32'h8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOffer("t4_stall_hold", 1'b1, 2'd3);
      checkOutput("t4_ovf_hold", 32'(overflow), 32'h8);
    end
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_ovf_clr", 32'(overflow), 32'h0);
    checkOffer("t4_after_clr", 1'b1, 2'd3);
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOffer("t4_done", 1'b0, 2'd0);
    checkOutput("t4_pending_done", 32'(pending), 32'h0);

    // Test 5: line 1 rises in the cycle its own event is accepted
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_pending", 32'(pending), 32'h6);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOffer("t5_id1", 1'b1, 2'd1);
    applyStimulus(4'b0110, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOffer("t5_next", 1'b1, 2'd2);
    checkOutput("t5_pending_kept", 32'(pending), 32'h6);
    checkOutput("t5_no_ovf", 32'(overflow), 32'h0);
    applyStimulus(4'b0110, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOffer("t5_reoffer", 1'b1, 2'd1);
    applyStimulus(4'b0110, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOffer("t5_idle", 1'b0, 2'd0);
    checkOutput("t5_pending_idle", 32'(pending), 32'h0);

    // Test 6: rises ignored with en low, then reset mid-offer
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_pending", 32'(pending), 32'h1);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_en_off", 32'(pending), 32'h1);
    checkOffer("t6_offer", 1'b1, 2'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_en_off2", 32'(pending), 32'h1);
    checkOutput("t6_no_ovf", 32'(overflow), 32'h0);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOffer("t6_rst", 1'b0, 2'd0);
    checkOutput("t6_rst_pending", 32'(pending), 32'h0);
    checkOutput("t6_rst_overflow", 32'(overflow), 32'h0);
    checkOutput("t6_rst_dbg", 32'(dbgState), 32'd0);
    checkOutput("t6_rst_id", 32'(evtId), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
